// File: rtl/stage4_pkg.sv
// rtl/stage4_pkg.sv - shared state encoding, opcodes and write-back types for the memory-access stage
package stage4_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_DUMP   = 3'd2;
  localparam logic [2:0] S_HALTED = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_WAIT   = S_WAIT,
    ST_DUMP   = S_DUMP,
    ST_HALTED = S_HALTED,
    ST_ERR    = S_ERR
  } state_t;

  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam logic [4:0] OPC_NOP  = 5'b00001;

  localparam int DEFAULT_TIMEOUT = 64;

  typedef struct packed {
    logic reg_write;
    logic jump_br;
    logic valid;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - MEM/WB pipeline register; a bubble clears controls and holds data fields
module wb_pipe_reg
  import stage4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] write_data_d,
  input  logic [15:0] pc_plus2_d,
  input  logic [15:0] instruction_d,
  input  logic [2:0]  write_reg_d,
  input  wb_ctrl_t    ctrl_d,
  output logic [15:0] write_data_q,
  output logic [15:0] pc_plus2_q,
  output logic [15:0] instruction_q,
  output logic [2:0]  write_reg_q,
  output wb_ctrl_t    ctrl_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_data_q  <= '0;
      pc_plus2_q    <= '0;
      instruction_q <= '0;
      write_reg_q   <= '0;
      ctrl_q        <= '0;
    end else if (load) begin
      write_data_q  <= write_data_d;
      pc_plus2_q    <= pc_plus2_d;
      instruction_q <= instruction_d;
      write_reg_q   <= write_reg_d;
      ctrl_q        <= ctrl_d;
    end else begin
      // Bubble: data fields keep feeding forwarding, but nothing writes back.
      ctrl_q <= '0;
    end
  end

endmodule

// File: rtl/stage4_mem_ctrl.sv
// rtl/stage4_mem_ctrl.sv - memory-access stage: issues multi-cycle data memory requests and owns MEM/WB
module stage4_mem_ctrl
  import stage4_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUout,
  input  logic [15:0] writeData,
  input  logic [15:0] pcPlus2,
  input  logic [15:0] instruction,
  input  logic [2:0]  writeReg,
  input  logic        RegWrite,
  input  logic        DMemWrite,
  input  logic        DMemEn,
  input  logic        MemToReg,
  input  logic        DMemDump,
  input  logic        Jump_Br,
  input  logic        nop,
  input  logic [15:0] mem_data_out,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_dump,
  output logic        stall,
  output logic        err,
  output logic        halt,
  output logic [15:0] writeData_s5,
  output logic [15:0] pcPlus2_s5,
  output logic [15:0] instruction_s5,
  output logic [2:0]  writeReg_s5,
  output logic        RegWrite_s5,
  output logic        Jump_Br_s5,
  output logic        valid_s5
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        valid_in, mem_op, dump_op;
  logic        req_load;
  logic [15:0] req_addr, req_data, req_pc, req_instr;
  logic [2:0]  req_wreg;
  logic        req_wr, req_regwrite, req_memtoreg, req_jump;

  logic        wb_load;
  logic [15:0] wb_data, wb_pc, wb_instr;
  logic [2:0]  wb_reg;
  logic        wb_regwrite, wb_jump;
  wb_ctrl_t    wb_ctrl_d, wb_ctrl_q;

  assign valid_in = ~nop;
  assign mem_op   = valid_in & DMemEn;
  assign dump_op  = valid_in & DMemDump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request register: upstream is frozen during WAIT, but the strobes and capture use this copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr     <= '0;
      req_data     <= '0;
      req_pc       <= '0;
      req_instr    <= '0;
      req_wreg     <= '0;
      req_wr       <= 1'b0;
      req_regwrite <= 1'b0;
      req_memtoreg <= 1'b0;
      req_jump     <= 1'b0;
    end else if (req_load) begin
      req_addr     <= ALUout;
      req_data     <= writeData;
      req_pc       <= pcPlus2;
      req_instr    <= instruction;
      req_wreg     <= writeReg;
      req_wr       <= DMemWrite;
      req_regwrite <= RegWrite;
      req_memtoreg <= MemToReg;
      req_jump     <= Jump_Br;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_load    = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_dump    = 1'b0;
    stall       = 1'b0;
    wb_load     = 1'b0;
    wb_data     = ALUout;
    wb_pc       = pcPlus2;
    wb_instr    = instruction;
    wb_reg      = writeReg;
    wb_regwrite = RegWrite;
    wb_jump     = Jump_Br;
    // Gating on rst drops the strobes the instant reset is asserted, even mid-request.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (mem_op && ALUout[0]) begin
            stall   = 1'b1;
            state_d = ST_ERR;
          end else if (mem_op) begin
            mem_addr    = ALUout;
            mem_data_in = writeData;
            mem_rd      = ~DMemWrite;
            mem_wr      = DMemWrite;
            req_load    = 1'b1;
            if (mem_err) begin
              stall   = 1'b1;
              state_d = ST_ERR;
            end else if (mem_done) begin
              wb_load = 1'b1;
              wb_data = MemToReg ? mem_data_out : ALUout;
            end else begin
              stall   = 1'b1;
              state_d = ST_WAIT;
            end
          end else if (dump_op) begin
            mem_dump = 1'b1;
            stall    = 1'b1;
            state_d  = ST_DUMP;
          end else begin
            wb_load = valid_in;
          end
        end
        ST_WAIT: begin
          mem_addr    = req_addr;
          mem_data_in = req_data;
          mem_rd      = ~req_wr;
          mem_wr      = req_wr;
          wb_pc       = req_pc;
          wb_instr    = req_instr;
          wb_reg      = req_wreg;
          wb_regwrite = req_regwrite;
          wb_jump     = req_jump;
          cnt_d       = cnt_q + 1'b1;
          if (mem_err) begin
            stall   = 1'b1;
            state_d = ST_ERR;
          end else if (mem_done) begin
            wb_load = 1'b1;
            wb_data = req_memtoreg ? mem_data_out : req_addr;
            state_d = ST_IDLE;
          end else begin
            stall = 1'b1;
            // The issue cycle counts too, so the strobe is held exactly TIMEOUT cycles.
            if (cnt_q == CNT_W'(TIMEOUT - 2)) state_d = ST_ERR;
          end
        end
        ST_DUMP: begin
          mem_dump = 1'b1;
          stall    = 1'b1;
          if (mem_err)       state_d = ST_ERR;
          else if (mem_done) state_d = ST_HALTED;
        end
        ST_HALTED: stall = 1'b1;
        ST_ERR:    stall = 1'b1;
        default:   state_d = ST_ERR;
      endcase
    end
  end

  assign wb_ctrl_d = '{reg_write: wb_regwrite, jump_br: wb_jump, valid: 1'b1};

  wb_pipe_reg u_wb_pipe_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (wb_load),
    .write_data_d  (wb_data),
    .pc_plus2_d    (wb_pc),
    .instruction_d (wb_instr),
    .write_reg_d   (wb_reg),
    .ctrl_d        (wb_ctrl_d),
    .write_data_q  (writeData_s5),
    .pc_plus2_q    (pcPlus2_s5),
    .instruction_q (instruction_s5),
    .write_reg_q   (writeReg_s5),
    .ctrl_q        (wb_ctrl_q)
  );

  assign RegWrite_s5 = wb_ctrl_q.reg_write;
  assign Jump_Br_s5  = wb_ctrl_q.jump_br;
  assign valid_s5    = wb_ctrl_q.valid;

  assign err  = (state_q == ST_ERR);
  assign halt = (state_q == ST_HALTED);

endmodule
